loeffler_idct: RTL and testbench
================================

Name: loeffler_idct

Overview:
- Pipelined 8-point 1-D inverse DCT using the Loeffler factorisation; the decode-side counterpart of the forward loeffler_dct.
- Accepts 8 dequantised signed coefficients per cycle and produces 8 reconstructed, saturated 8-bit samples.
- Used twice (rows, then columns via transpose buffer) in the JPEG decoder's 8x8 IDCT path.
- Valid/ready handshake on both sides; global stall on output backpressure.

Parameters:
- IN_W, 12: signed width of each input coefficient.
- CONST_FRAC, 13: fractional bits of the fixed-point cosine constants and internal datapath.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_in  in  1  idct_in carries a vector this cycle
- ready_in  out  1  block can accept a vector this cycle
- idct_in  in  8 x IN_W signed  coefficients X[0..7]; index 0 is DC
- valid_out  out  1  idct_out holds a result
- ready_out  in  1  downstream accepts idct_out this cycle
- idct_out  out  8 x 8  samples x[0..7]; signed, or unsigned with LEVEL_SHIFT_EN

Behaviour:
- Function: x[n] = round( 0.5 * sum_k C(k) * X[k] * cos((2n+1)*k*pi/16) ), where C(0) = 1/sqrt2 and C(k>0) = 1.
  - Rounding is to nearest, half away from zero.
  - Result must be within +/-1 LSB of the double-precision result.
  - All-zero input gives exact 0. DC-only input gives the exact rounded value on all 8 outputs.
- Datapath:
  - Internal width is IN_W+CONST_FRAC+4 signed; no internal overflow for any IN_W input.
  - Final stage rounds, drops CONST_FRAC bits, then saturates to [-128, 127].
- Pipeline: 4 register stages, butterfly/rotation split across them.
  - Latency is exactly 4 cycles from an accepted input to valid_out when not stalled.
  - Throughput is 1 vector per cycle.
- Handshake:
  - Accept = valid_in & ready_in.
  - ready_in = ready_out | ~valid_out (combinational).
  - advance = ready_in. When advance=0, every stage (data and valid) holds.
  - valid_in while ready_in=0 is ignored; upstream must hold its data.
  - idct_out and valid_out stay stable while valid_out=1 and ready_out=0.
  - Bubbles are not compressed; each stage carries its own valid bit.
- Reset:
  - All stage valid bits, valid_out and idct_out go to 0 on the cycle after rst is sampled high.
  - Applies mid-operation and mid-stall: all in-flight vectors are discarded.
  - ready_in is 1 immediately after reset.
- Simultaneous events:
  - Accept and output handoff in the same cycle is legal; the pipeline shifts.
  - rst has priority over all handshakes.

Optional Feature:
- Macro: LEVEL_SHIFT_EN.
- Defined: 128 is added after rounding, before saturation. Saturation range is [0, 255] and idct_out is unsigned.
- Undefined: output is signed and saturated to [-128, 127].
- Latency and handshake are identical in both builds.

Test Plan:
- Zero vector: X = all 0 accepted at cycle t -> valid_out at t+4; all x = 0 (128 with LEVEL_SHIFT_EN).
- DC only: X0 = 64, rest 0 -> all x = 23 (151 with LEVEL_SHIFT_EN). X0 = -64 -> all x = -23 (105).
- AC1: X1 = 100, rest 0 -> x = {49, 42, 28, 10, -10, -28, -42, -49}, +/-1 allowed on non-exact entries.
- Saturation: X0 = 1000 -> all x = 127 (255). X0 = -1000 -> all x = -128 (0). X0 = 2047 with IN_W = 12 -> 127, no wrap.
- Streaming plus backpressure:
  - 8 back-to-back vectors (X0 = 8*i, rest 0); ready_out low for 3 cycles once the first result appears.
  - Required: ready_in = 0 during the stall, idct_out stable, no vector lost or duplicated, results in order.
- Reset mid-operation: 3 vectors in flight; rst high for 1 cycle -> valid_out = 0 and idct_out = 0 next cycle; no stale outputs; a new vector accepted afterwards emerges 4 cycles later.

Source files
------------

// File: rtl/loeffler_idct.sv
// loeffler_idct: pipelined 8-point 1-D inverse DCT (even/odd Loeffler split)
// with four register stages, valid/ready handshake and a global stall.
// Optional build macro LEVEL_SHIFT_EN: adds 128 before saturation and
// produces unsigned [0,255] samples instead of signed [-128,127].
module loeffler_idct #(
  parameter int IN_W       = 12,
  parameter int CONST_FRAC = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  output logic                 ready_in,
  input  logic [7:0][IN_W-1:0] idct_in,
  output logic                 valid_out,
  input  logic                 ready_out,
  output logic [7:0][7:0]      idct_out
);

  localparam int  IW    = IN_W + CONST_FRAC + 4;
  localparam int  SW    = IN_W + 1;
  localparam real SCALE = 2.0 ** CONST_FRAC;

  // 0.5 * cos(k*pi/16), the 1/2 of the transform folded into every constant
  localparam logic signed [IW-1:0] C1 = IW'($rtoi(0.4903926402016152 * SCALE + 0.5));
  localparam logic signed [IW-1:0] C2 = IW'($rtoi(0.4619397662556434 * SCALE + 0.5));
  localparam logic signed [IW-1:0] C3 = IW'($rtoi(0.4157348061512726 * SCALE + 0.5));
  localparam logic signed [IW-1:0] C4 = IW'($rtoi(0.3535533905932738 * SCALE + 0.5));
  localparam logic signed [IW-1:0] C5 = IW'($rtoi(0.2777851165098011 * SCALE + 0.5));
  localparam logic signed [IW-1:0] C6 = IW'($rtoi(0.1913417161825449 * SCALE + 0.5));
  localparam logic signed [IW-1:0] C7 = IW'($rtoi(0.0975451610080641 * SCALE + 0.5));

  localparam logic signed [IW-1:0] HALF = IW'(1) <<< (CONST_FRAC - 1);

`ifdef LEVEL_SHIFT_EN
  localparam logic signed [IW-1:0] SHIFT  = IW'(128);
  localparam logic signed [IW-1:0] SAT_LO = IW'(0);
  localparam logic signed [IW-1:0] SAT_HI = IW'(255);
`else
  localparam logic signed [IW-1:0] SHIFT  = IW'(0);
  localparam logic signed [IW-1:0] SAT_LO = IW'(-128);
  localparam logic signed [IW-1:0] SAT_HI = IW'(127);
`endif

  // Round to nearest, ties away from zero, dropping CONST_FRAC bits
  function automatic logic signed [IW-1:0] round_frac(input logic signed [IW-1:0] v);
    if (v < 0) round_frac = (v + HALF - IW'(1)) >>> CONST_FRAC;
    else       round_frac = (v + HALF) >>> CONST_FRAC;
  endfunction

  // Optional level shift, then clamp to the 8-bit output range
  function automatic logic [7:0] sat8(input logic signed [IW-1:0] v);
    logic signed [IW-1:0] s;
    s = v + SHIFT;
    if (s > SAT_HI)      sat8 = SAT_HI[7:0];
    else if (s < SAT_LO) sat8 = SAT_LO[7:0];
    else                 sat8 = s[7:0];
  endfunction

  function automatic logic [7:0] finish_lane(input logic signed [IW-1:0] v);
    finish_lane = sat8(round_frac(v));
  endfunction

  logic                   advance;
  logic signed [IN_W-1:0] coef [8];

  logic                   vld_p0, vld_p1, vld_p2;
  logic signed [SW-1:0]   s04_p0, d04_p0;
  logic signed [IN_W-1:0] x1_p0, x2_p0, x3_p0, x5_p0, x6_p0, x7_p0;
  logic signed [IW-1:0]   a0_p1, a1_p1, a2_p1, a3_p1;
  logic signed [IW-1:0]   o0_p1, o1_p1, o2_p1, o3_p1;
  logic signed [IW-1:0]   e0_p2, e1_p2, e2_p2, e3_p2;
  logic signed [IW-1:0]   o0_p2, o1_p2, o2_p2, o3_p2;

  assign ready_in = ready_out | ~valid_out;
  assign advance  = ready_in;

  // Reinterpret the packed input lanes as signed coefficients
  always_comb begin
    for (int i = 0; i < 8; i++) coef[i] = idct_in[i];
  end

  // Datapath registers: shift only when the pipeline advances
  always_ff @(posedge clk) begin
    if (advance) begin
      // stage p0: DC/X4 butterfly, pass remaining coefficients
      s04_p0 <= SW'(coef[0]) + SW'(coef[4]);
      d04_p0 <= SW'(coef[0]) - SW'(coef[4]);
      x1_p0  <= coef[1];
      x2_p0  <= coef[2];
      x3_p0  <= coef[3];
      x5_p0  <= coef[5];
      x6_p0  <= coef[6];
      x7_p0  <= coef[7];
      // stage p1: even rotations and odd-part dot products
      a0_p1 <= IW'(s04_p0) * C4;
      a1_p1 <= IW'(d04_p0) * C4;
      a2_p1 <= IW'(x2_p0) * C6 - IW'(x6_p0) * C2;
      a3_p1 <= IW'(x2_p0) * C2 + IW'(x6_p0) * C6;
      o0_p1 <= IW'(x1_p0) * C1 + IW'(x3_p0) * C3 + IW'(x5_p0) * C5 + IW'(x7_p0) * C7;
      o1_p1 <= IW'(x1_p0) * C3 - IW'(x3_p0) * C7 - IW'(x5_p0) * C1 - IW'(x7_p0) * C5;
      o2_p1 <= IW'(x1_p0) * C5 - IW'(x3_p0) * C1 + IW'(x5_p0) * C7 + IW'(x7_p0) * C3;
      o3_p1 <= IW'(x1_p0) * C7 - IW'(x3_p0) * C5 + IW'(x5_p0) * C3 - IW'(x7_p0) * C1;
      // stage p2: even-part butterfly, odd terms carried
      e0_p2 <= a0_p1 + a3_p1;
      e1_p2 <= a1_p1 + a2_p1;
      e2_p2 <= a1_p1 - a2_p1;
      e3_p2 <= a0_p1 - a3_p1;
      o0_p2 <= o0_p1;
      o1_p2 <= o1_p1;
      o2_p2 <= o2_p1;
      o3_p2 <= o3_p1;
    end
  end

  // Valid bits and output stage; reset discards everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      valid_out <= 1'b0;
      idct_out  <= '0;
    end else if (advance) begin
      vld_p0    <= valid_in;
      vld_p1    <= vld_p0;
      vld_p2    <= vld_p1;
      valid_out <= vld_p2;
      // stage p3: final butterfly, round and saturate
      if (vld_p2) begin
        idct_out[0] <= finish_lane(e0_p2 + o0_p2);
        idct_out[7] <= finish_lane(e0_p2 - o0_p2);
        idct_out[1] <= finish_lane(e1_p2 + o1_p2);
        idct_out[6] <= finish_lane(e1_p2 - o1_p2);
        idct_out[2] <= finish_lane(e2_p2 + o2_p2);
        idct_out[5] <= finish_lane(e2_p2 - o2_p2);
        idct_out[3] <= finish_lane(e3_p2 + o3_p2);
        idct_out[4] <= finish_lane(e3_p2 - o3_p2);
      end
    end
  end

endmodule

// File: tb/tb_loeffler_idct.sv
// Testbench for loeffler_idct: directed vectors, queue scoreboard, decoupled
// output monitor. Honours LEVEL_SHIFT_EN when the build defines it.
module tb_loeffler_idct;

  localparam int IN_W = 12;

`ifdef LEVEL_SHIFT_EN
  localparam int SHIFT = 128;
  localparam int LO    = 0;
  localparam int HI    = 255;
`else
  localparam int SHIFT = 0;
  localparam int LO    = -128;
  localparam int HI    = 127;
`endif

  typedef int vec8_t [8];

  typedef struct {
    logic [63:0] lanes;
    int          tol;
    int          id;
    int          acc_edge;
    int          acc_stall;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 valid_in;
  logic                 ready_in;
  logic [7:0][IN_W-1:0] idct_in;
  logic                 valid_out;
  logic                 ready_out;
  logic [7:0][7:0]      idct_out;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   stalls = 0;
  int   next_id = 0;

  loeffler_idct #(.IN_W(IN_W), .CONST_FRAC(13)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .ready_in (ready_in),
    .idct_in  (idct_in),
    .valid_out(valid_out),
    .ready_out(ready_out),
    .idct_out (idct_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] exp_lane(input int ideal);
    int          v;
    logic [31:0] t;
    v = ideal + SHIFT;
    if (v < LO) v = LO;
    if (v > HI) v = HI;
    t = v;
    return t[7:0];
  endfunction

  function automatic int lane_val(input logic [7:0] b);
`ifdef LEVEL_SHIFT_EN
    return int'(b);
`else
    return int'($signed(b));
`endif
  endfunction

  // Scoreboard monitor: a handoff happens on the next edge when both valid_out and ready_out are high
  always @(negedge clk) begin
    if (!rst && valid_out && !ready_out) stalls++;
    if (!rst && valid_out && ready_out) begin
      exp_t e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %h with no vector outstanding", idct_out);
      end else begin
        bit bad;
        int lat;
        e = q.pop_front();
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
          int d;
          d = lane_val(idct_out[i]) - lane_val(e.lanes[i*8 +: 8]);
          if (d > e.tol || d < -e.tol) bad = 1'b1;
        end
        if (bad) begin
          errors++;
          $display("FAIL data_vec%0d: got %h expected %h (tol %0d)", e.id, idct_out, e.lanes, e.tol);
        end
        checks++;
        lat = (cyc + 1) - e.acc_edge - (stalls - e.acc_stall);
        if (lat != 4) begin
          errors++;
          $display("FAIL latency_vec%0d: got %0d expected 4", e.id, lat);
        end
      end
    end
  end

  // Present one vector and hold it until accepted; record its expected result
  task automatic send(input vec8_t x, input vec8_t ideal, input int tol);
    exp_t e;
    int   n;
    valid_in = 1'b1;
    for (int k = 0; k < 8; k++) idct_in[k] = IN_W'(x[k]);
    n = 0;
    @(negedge clk);
    while (!ready_in && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready_in) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: ready_in got 0 expected 1 within 100 cycles");
    end else begin
      for (int i = 0; i < 8; i++) e.lanes[i*8 +: 8] = exp_lane(ideal[i]);
      e.tol       = tol;
      e.id        = next_id;
      e.acc_edge  = cyc + 1;
      e.acc_stall = stalls;
      q.push_back(e);
    end
    next_id++;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic send_dc(input int x0, input int ideal);
    vec8_t x, y;
    for (int i = 0; i < 8; i++) begin
      x[i] = 0;
      y[i] = ideal;
    end
    x[0] = x0;
    send(x, y, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0 || idct_out !== '0 || ready_in !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got valid_out=%b idct_out=%h ready_in=%b expected 0 0 1",
               valid_out, idct_out, ready_in);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outstanding expected 0", q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int stream_exp [8];
    stream_exp = '{0, 3, 6, 8, 11, 14, 17, 20};
    rst       = 1'b1;
    valid_in  = 1'b0;
    ready_out = 1'b1;
    idct_in   = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Directed single vectors, issued back to back
    send('{0, 0, 0, 0, 0, 0, 0, 0},   '{0, 0, 0, 0, 0, 0, 0, 0}, 0);
    send_dc(64, 23);
    send_dc(-64, -23);
    send('{0, 100, 0, 0, 0, 0, 0, 0}, '{49, 42, 28, 10, -10, -28, -42, -49}, 1);
    send('{0, 0, 100, 0, 0, 0, 0, 0}, '{46, 19, -19, -46, -46, -19, 19, 46}, 1);
    send('{0, 0, 0, 100, 0, 0, 0, 0}, '{42, -10, -49, -28, 28, 49, 10, -42}, 1);
    send('{0, 0, 0, 0, 100, 0, 0, 0}, '{35, -35, -35, 35, 35, -35, -35, 35}, 1);
    send('{0, 0, 0, 0, 0, 100, 0, 0}, '{28, -49, 10, 42, -42, -10, 49, -28}, 1);
    send('{0, 0, 0, 0, 0, 0, 100, 0}, '{19, -46, 46, -19, -19, 46, -46, 19}, 1);
    send('{0, 0, 0, 0, 0, 0, 0, 100}, '{10, -28, 42, -49, 49, -42, 28, -10}, 1);
    send_dc(1000, 354);
    send_dc(-1000, -354);
    send_dc(2047, 724);
    send_dc(-2048, -724);
    drain();

    // Streaming with a 3-cycle output stall once the first result shows up
    fork
      begin
        for (int i = 0; i < 8; i++) send_dc(8 * i, stream_exp[i]);
      end
      begin
        int          n;
        logic [63:0] hold;
        n = 0;
        while (valid_out !== 1'b1 && n < 50) begin
          @(posedge clk);
          #1;
          n++;
        end
        checks++;
        if (valid_out !== 1'b1) begin
          errors++;
          $display("FAIL stream_first_result: valid_out got %b expected 1", valid_out);
        end else begin
          ready_out = 1'b0;
          hold = idct_out;
          for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (ready_in !== 1'b0 || valid_out !== 1'b1 || idct_out !== hold) begin
              errors++;
              $display("FAIL stall_cycle%0d: got ready_in=%b valid_out=%b out=%h expected 0 1 %h",
                       c, ready_in, valid_out, idct_out, hold);
            end
            @(posedge clk);
            #1;
          end
          ready_out = 1'b1;
        end
      end
    join
    drain();

    // Reset with three vectors in flight; none may emerge
    send_dc(64, 23);
    send_dc(-64, -23);
    send_dc(1000, 354);
    do_reset();
    send_dc(-1000, -354);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
